// File: rtl/shift_right_pipe_if.sv
// rtl/shift_right_pipe_if.sv - handshake bundle for the pipelined right shifter
interface shift_right_pipe_if #(
  parameter int LENGTH = 8
);
  localparam int STAGES = $clog2(LENGTH);

  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic [STAGES-1:0] in_shamt;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;

  // Producer/consumer side: drives words in and accepts results.
  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_right_pipe.sv
// rtl/shift_right_pipe.sv - flow-controlled right shifter, one register stage per shift-amount bit
module shift_right_pipe #(
  parameter int LENGTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_right_pipe_if.slave  bus
);
  localparam int STAGES = $clog2(LENGTH);

  // Per-stage registers; each word carries its own shift amount and mode.
  logic [STAGES-1:0] valid_q;
  logic [LENGTH-1:0] data_q  [STAGES];
  logic [STAGES-1:0] shamt_q [STAGES];
  logic [1:0]        mode_q  [STAGES];

  // Stage inputs (upstream view) and the shifted value each stage would load.
  logic [STAGES-1:0] src_valid;
  logic [LENGTH-1:0] src_data  [STAGES];
  logic [STAGES-1:0] src_shamt [STAGES];
  logic [1:0]        src_mode  [STAGES];
  logic [LENGTH-1:0] nxt_data  [STAGES];
  logic [STAGES-1:0] ready;

  // Stall chain: a stage may load unless it and every stage after it are full while the sink stalls.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    ready    = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      ready[k] = bus.out_ready | ~all_full;
    end
  end

  // Stage 0 is fed from the input port, later stages from the preceding register.
  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_shamt[0] = bus.in_shamt;
    src_mode[0]  = bus.in_mode;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
    end
  end

  // Stage k shifts by 2^k when its shamt bit is set; the fill pattern depends on the mode.
  always_comb begin
    logic [LENGTH-1:0] d;
    logic [LENGTH-1:0] fill;
    logic [LENGTH-1:0] shifted;
    int                amt;
    for (int k = 0; k < STAGES; k++) begin
      amt  = 1 << k;
      d    = src_data[k];
      fill = '0;
      case (src_mode[k])
        // Sign bit of the stage input equals the original sign bit, so replicating it is exact.
        2'b01:   fill = {LENGTH{d[LENGTH-1]}} & ~({LENGTH{1'b1}} >> amt);
        2'b10:   fill = d << (LENGTH - amt);
        default: fill = '0;
      endcase
      shifted     = (d >> amt) | fill;
      nxt_data[k] = src_shamt[k][k] ? shifted : d;
    end
  end

  // Pipeline registers: load on ready, hold otherwise; reset discards all in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_valid[k];
          data_q[k]  <= nxt_data[k];
          shamt_q[k] <= src_shamt[k];
          mode_q[k]  <= src_mode[k];
        end
      end
    end
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
endmodule

// File: tb/tb_shift_right_pipe.sv
// tb/tb_shift_right_pipe.sv - scoreboard bench for shift_right_pipe
module tb_shift_right_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  shift_right_pipe_if #(.LENGTH(8)) bus ();

  shift_right_pipe #(.LENGTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] shamt;
    logic [1:0] mode;
    logic [7:0] expect_data;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] sb [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         accepts = 0;
  int         pops = 0;
  int         first_pop_cyc = -1;
  int         last_pop_cyc = -1;
  logic       stall_prev = 1'b0;
  logic [7:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] m);
    logic [7:0] r;
    int s;
    for (int i = 0; i < 8; i++) begin
      s = i + int'(sh);
      if (s < 8)        r[i] = d[s];
      else if (m == 2)  r[i] = d[s-8];
      else if (m == 1)  r[i] = d[7];
      else              r[i] = 1'b0;
    end
    return r;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, advance to next negedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] sh,
                       input logic [1:0] m, input logic ordy, input logic [7:0] want);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_shamt  = sh;
    bus.in_mode   = m;
    bus.out_ready = ordy;
    #1;
    if (stall_prev)
      check("stall_hold", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, held});
    if (bus.out_valid && ordy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got %0h expected none (cycle %0d)", bus.out_data, cyc);
      end else begin
        check("out_data", bus.out_data, sb.pop_front());
      end
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (v && bus.in_ready) begin
      sb.push_back(want);
      accepts++;
    end
    stall_prev = bus.out_valid && !ordy;
    held       = bus.out_data;
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_cycle(input logic v, input logic ordy);
    logic [7:0] d;
    logic [2:0] sh;
    logic [1:0] m;
    d  = 8'($urandom);
    sh = 3'($urandom);
    m  = 2'($urandom);
    cycle(v, d, sh, m, ordy, ref_shift(d, sh, m));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      cycle(1'b0, 8'h00, 3'd0, 2'd0, 1'b1, 8'h00);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int acc0;
    int pop0;
    int n;
    vecs[0] = '{8'h80, 3'd3, 2'b00, 8'h10};
    vecs[1] = '{8'h80, 3'd3, 2'b01, 8'hF0};
    vecs[2] = '{8'h40, 3'd3, 2'b01, 8'h08};
    vecs[3] = '{8'h81, 3'd1, 2'b10, 8'hC0};
    vecs[4] = '{8'h01, 3'd7, 2'b10, 8'h02};
    vecs[5] = '{8'hA5, 3'd0, 2'b00, 8'hA5};
    vecs[6] = '{8'hA5, 3'd0, 2'b01, 8'hA5};
    vecs[7] = '{8'hA5, 3'd0, 2'b10, 8'hA5};
    vecs[8] = '{8'hA5, 3'd0, 2'b11, 8'hA5};
    vecs[9] = '{8'h80, 3'd3, 2'b11, 8'h10};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back to back.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, vecs[i].data, vecs[i].shamt, vecs[i].mode, 1'b1, vecs[i].expect_data);
    drain();

    // Streaming: 256 back-to-back words, latency and throughput.
    acc0 = cyc;
    pop0 = pops;
    first_pop_cyc = -1;
    for (int i = 0; i < 256; i++) rand_cycle(1'b1, 1'b1);
    drain();
    check("stream_latency", first_pop_cyc - acc0, 3);
    check("stream_count", pops - pop0, 256);
    check("stream_rate", last_pop_cyc - first_pop_cyc, 255);

    // Backpressure: sink stalled, source always valid.
    acc0 = accepts;
    for (int i = 0; i < 6; i++) rand_cycle(1'b1, 1'b0);
    check("bp_accepts", accepts - acc0, 3);
    #1;
    check("bp_in_ready", bus.in_ready, 0);
    acc0 = accepts;
    pop0 = pops;
    for (int i = 0; i < 4; i++) rand_cycle(1'b1, 1'b1);
    check("bp_push_pop_acc", accepts - acc0, 4);
    check("bp_push_pop_pop", pops - pop0, 4);
    drain();

    // Random valid/ready with 30% stall on each side, 10k words.
    acc0 = accepts;
    n = 0;
    while (accepts - acc0 < 10000 && n < 40000) begin
      rand_cycle($urandom_range(0, 99) >= 30, $urandom_range(0, 99) >= 30);
      n++;
    end
    check("rand_accepts", accepts - acc0, 10000);
    drain();

    // Reset with three words in flight.
    for (int i = 0; i < 4; i++) rand_cycle(1'b1, 1'b0);
    check("pre_reset_full", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_out_data", bus.out_data, 0);
    check("async_in_ready", bus.in_ready, 1);
    sb.delete();
    stall_prev = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) rand_cycle(1'b1, 1'b1);
    drain();
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 3'd0, 2'd0, 1'b1, 8'h00);
    check("post_reset_idle", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
